// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one alu between two requesters, one op in flight at a time.
// Define ALU_ARB_STATS_EN to add saturating per-requester grant counters (grant_cnt0/grant_cnt1).

module alu_arbiter #(
   parameter int N       = 8,
   parameter int ALU_LAT = 1
) (
   input  logic         clk,
   input  logic         rst_n,
`ifdef ALU_ARB_STATS_EN
   output logic [15:0]  grant_cnt0,
   output logic [15:0]  grant_cnt1,
`endif
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [2:0]   req0_mode,
   input  logic [N-1:0] req0_a,
   input  logic [N-1:0] req0_b,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [2:0]   req1_mode,
   input  logic [N-1:0] req1_a,
   input  logic [N-1:0] req1_b,
   output logic         resp0_valid,
   input  logic         resp0_ready,
   output logic         resp1_valid,
   input  logic         resp1_ready,
   output logic [N-1:0] resp_out,
   output logic         resp_zero,
   output logic         resp_carry,
   output logic         alu_enable,
   output logic [2:0]   alu_mode,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   input  logic [N-1:0] alu_out,
   input  logic         alu_zero,
   input  logic         alu_carry
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WAIT, S_RESP} state_t;

   localparam int                WCNT_W    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
   localparam logic [WCNT_W-1:0] WCNT_INIT = WCNT_W'(ALU_LAT - 1);

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_grant_q, last_grant_d;
   logic [2:0]        mode_q, mode_d;
   logic [N-1:0]      a_q, a_d;
   logic [N-1:0]      b_q, b_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic [N-1:0]      out_q, out_d;
   logic              zero_q, zero_d;
   logic              carry_q, carry_d;

   logic              grant;
   logic              grant_vld;
   logic              accept;
   logic              resp_take;
   logic [2:0]        gnt_mode;
   logic [N-1:0]      gnt_a;
   logic [N-1:0]      gnt_b;

   // On a tie the requester that did not win last time gets the alu.
   always_comb begin
      grant     = 1'b0;
      grant_vld = 1'b0;
      if (req0_valid && req1_valid) begin
         grant     = ~last_grant_q;
         grant_vld = 1'b1;
      end else if (req0_valid) begin
         grant     = 1'b0;
         grant_vld = 1'b1;
      end else if (req1_valid) begin
         grant     = 1'b1;
         grant_vld = 1'b1;
      end
   end

   always_comb begin
      gnt_mode = grant ? req1_mode : req0_mode;
      gnt_a    = grant ? req1_a    : req0_a;
      gnt_b    = grant ? req1_b    : req0_b;
   end

   assign accept    = (state_q == S_IDLE) && grant_vld;
   assign resp_take = owner_q ? resp1_ready : resp0_ready;

   // Next-state process.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept)       state_d = S_EXEC;
         S_EXEC:                    state_d = S_WAIT;
         S_WAIT:  if (wcnt_q == '0) state_d = S_RESP;
         S_RESP:  if (resp_take)    state_d = S_IDLE;
         default:                   state_d = S_IDLE;
      endcase
   end

   // NOTE: every *_d starts as its *_q so no branch leaves a value unassigned and infers a latch.
   always_comb begin
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      mode_d       = mode_q;
      a_d          = a_q;
      b_d          = b_q;
      wcnt_d       = wcnt_q;
      out_d        = out_q;
      zero_d       = zero_q;
      carry_d      = carry_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               owner_d      = grant;
               last_grant_d = grant;
               mode_d       = gnt_mode;
               a_d          = gnt_a;
               b_d          = gnt_b;
            end
         end
         S_EXEC: wcnt_d = WCNT_INIT;
         S_WAIT: begin
            if (wcnt_q == '0) begin
               out_d   = alu_out;
               zero_d  = alu_zero;
               carry_d = alu_carry;
            end else begin
               wcnt_d = wcnt_q - WCNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   // NOTE: the operand and result flops are reset along with the control state, because every
   // output they drive must read 0 while rst_n is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         mode_q       <= '0;
         a_q          <= '0;
         b_q          <= '0;
         wcnt_q       <= '0;
         out_q        <= '0;
         zero_q       <= 1'b0;
         carry_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         mode_q       <= mode_d;
         a_q          <= a_d;
         b_q          <= b_d;
         wcnt_q       <= wcnt_d;
         out_q        <= out_d;
         zero_q       <= zero_d;
         carry_q      <= carry_d;
      end
   end

   // Output process. The ready terms are gated by rst_n so they stay low during reset even if
   // a requester keeps valid asserted.
   always_comb begin
      req0_ready  = rst_n && accept && !grant;
      req1_ready  = rst_n && accept &&  grant;
      resp0_valid = (state_q == S_RESP) && !owner_q;
      resp1_valid = (state_q == S_RESP) &&  owner_q;
      resp_out    = out_q;
      resp_zero   = zero_q;
      resp_carry  = carry_q;
      alu_enable  = (state_q == S_EXEC);
      alu_mode    = mode_q;
      alu_a       = a_q;
      alu_b       = b_q;
   end

`ifdef ALU_ARB_STATS_EN
   logic [15:0] grant_cnt0_q, grant_cnt0_d;
   logic [15:0] grant_cnt1_q, grant_cnt1_d;

   always_comb begin
      grant_cnt0_d = grant_cnt0_q;
      grant_cnt1_d = grant_cnt1_q;
      if (accept && !grant && (grant_cnt0_q != 16'hFFFF)) grant_cnt0_d = grant_cnt0_q + 16'd1;
      if (accept &&  grant && (grant_cnt1_q != 16'hFFFF)) grant_cnt1_d = grant_cnt1_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt0_q <= '0;
         grant_cnt1_q <= '0;
      end else begin
         grant_cnt0_q <= grant_cnt0_d;
         grant_cnt1_q <= grant_cnt1_d;
      end
   end

   assign grant_cnt0 = grant_cnt0_q;
   assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule
